// File: rtl/memory_writeback.sv
// Memory/writeback stage: ALU results retire 1 cycle after accept; loads 2 cycles + bus wait, stores 1 cycle + bus wait.
// in_ready is high only in IDLE, so any memory op stalls upstream until the bus acks and writeback completes.
module memory_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              wb_reg,
  input  logic [REG_W-1:0]  rd_num,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              misalign
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              misalign_q, misalign_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

  logic              is_load, is_store, legal, misaligned;
  logic [1:0]        off_in;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  assign off_in   = rd_data[1:0];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign in_ready = (state_q == IDLE);

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
              (func3 == 3'b100) || (func3 == 3'b101);
    end else if (is_store) begin
      legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    end
    misaligned = ((func3[1:0] == 2'b01) && off_in[0]) ||
                 ((func3 == 3'b010) && (off_in != 2'b00));
  end

  // Load data is formatted on the ack cycle so WB only has to present it.
  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    misalign_d   = 1'b0;
    rd_d         = rd_q;
    f3_d         = f3_q;
    off_d        = off_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_load && !is_store) begin
            rf_we_d    = wb_reg && (rd_num != '0);
            rf_waddr_d = rd_num;
            rf_wdata_d = rd_data;
          end else if (!legal || misaligned) begin
            misalign_d = 1'b1;
          end else begin
            rd_d         = rd_num;
            f3_d         = func3;
            off_d        = off_in;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {rd_data[DATA_W-1:2], 2'b00};
            case (func3[1:0])
              2'b00: begin
                dmem_be_d    = 4'b0001 << off_in;
                dmem_wdata_d = {(DATA_W/8){rs2_data[7:0]}};
              end
              2'b01: begin
                dmem_be_d    = 4'b0011 << off_in;
                dmem_wdata_d = {(DATA_W/16){rs2_data[15:0]}};
              end
              default: begin
                dmem_be_d    = 4'b1111;
                dmem_wdata_d = rs2_data;
              end
            endcase
            state_d = MEM;
          end
        end
      end
      MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            state_d = IDLE;
          end else begin
            rf_we_d    = (rd_q != '0);
            rf_waddr_d = rd_q;
            rf_wdata_d = ld_data;
            state_d    = WB;
          end
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      misalign_q   <= 1'b0;
      rd_q         <= '0;
      f3_q         <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      misalign_q   <= misalign_d;
      rd_q         <= rd_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Directed bench for memory_writeback: ALU stream, store lanes, load formatting, misalign, zero-wait ack, reset abort.
module tb_memory_writeback;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        wb_reg;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic [31:0] rs2_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  memory_writeback #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .wb_reg(wb_reg), .rd_num(rd_num),
    .rd_data(rd_data), .rs2_data(rs2_data), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic wb,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] s);
    in_valid = 1'b1;
    opcode   = op;
    func3    = f3;
    wb_reg   = wb;
    rd_num   = rd;
    rd_data  = a;
    rs2_data = s;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] word,
                         input logic [31:0] exp, input int waits);
    issue(OP_LOAD, f3, 1'b1, rd, a, 32'h0);
    step();
    in_valid = 1'b0;
    check({tag, "_req"}, dmem_req, 1);
    check({tag, "_we"}, dmem_we, 0);
    check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    for (int i = 0; i < waits; i++) step();
    dmem_ack   = 1'b1;
    dmem_rdata = word;
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    check({tag, "_rfwe"}, rf_we, 1);
    check({tag, "_waddr"}, rf_waddr, rd);
    check({tag, "_wdata"}, rf_wdata, exp);
    check({tag, "_rdy_wb"}, in_ready, 0);
    step();
    check({tag, "_rfwe_off"}, rf_we, 0);
    check({tag, "_rdy_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = 7'h0; func3 = 3'h0; wb_reg = 1'b0;
    rd_num = 5'h0; rd_data = 32'h0; rs2_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step();
    step();
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_rfwe", rf_we, 0);
    check("rst_mis", misalign, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_rfwaddr", rf_waddr, 0);
    check("rst_rfwdata", rf_wdata, 0);
    rst = 1'b0;
    step();
    check("rst_ready", in_ready, 1);

    // ALU stream: x5, x6, x0
    issue(OP_ALU, 3'b000, 1'b1, 5'd5, 32'h11, 32'h0);
    step();
    check("alu0_we", rf_we, 1);
    check("alu0_addr", rf_waddr, 5);
    check("alu0_data", rf_wdata, 32'h11);
    check("alu0_rdy", in_ready, 1);
    issue(OP_ALU, 3'b000, 1'b1, 5'd6, 32'h22, 32'h0);
    step();
    check("alu1_we", rf_we, 1);
    check("alu1_addr", rf_waddr, 6);
    check("alu1_data", rf_wdata, 32'h22);
    check("alu1_rdy", in_ready, 1);
    issue(OP_ALU, 3'b000, 1'b1, 5'd0, 32'h33, 32'h0);
    step();
    check("alu2_we_x0", rf_we, 0);
    check("alu2_rdy", in_ready, 1);
    in_valid = 1'b0;
    step();
    check("alu_idle_we", rf_we, 0);

    // SB at 0x103, ack on the third MEM cycle
    issue(OP_STORE, 3'b000, 1'b0, 5'd0, 32'h103, 32'hAABBCCDD);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("sb_req", dmem_req, 1);
      check("sb_we", dmem_we, 1);
      check("sb_addr", dmem_addr, 32'h100);
      check("sb_be", dmem_be, 4'b1000);
      check("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
      check("sb_rfwe", rf_we, 0);
      check("sb_rdy", in_ready, 0);
      if (c == 2) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    check("sb_done_req", dmem_req, 0);
    check("sb_done_rdy", in_ready, 1);
    check("sb_done_rfwe", rf_we, 0);

    // SH at 0x102 with zero-wait ack
    issue(OP_STORE, 3'b001, 1'b0, 5'd0, 32'h102, 32'h1234ABCD);
    step();
    in_valid = 1'b0;
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    check("sh_addr", dmem_addr, 32'h100);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("sh_done_rdy", in_ready, 1);
    check("sh_done_rfwe", rf_we, 0);

    // Load sign/zero extension from word 0x80FF7F01
    do_load("lb",  3'b000, 32'h2, 5'd1, 32'h80FF7F01, 32'hFFFFFFFF, 1);
    do_load("lbu", 3'b100, 32'h2, 5'd2, 32'h80FF7F01, 32'h000000FF, 0);
    do_load("lh",  3'b001, 32'h2, 5'd3, 32'h80FF7F01, 32'hFFFF80FF, 2);
    do_load("lw",  3'b010, 32'h0, 5'd4, 32'h80FF7F01, 32'h80FF7F01, 0);
    do_load("lhu", 3'b101, 32'h0, 5'd8, 32'h80FF7F01, 32'h00007F01, 1);
    do_load("lb1", 3'b000, 32'h1, 5'd9, 32'h80FF7F01, 32'h0000007F, 0);

    // Misaligned and illegal ops
    issue(OP_LOAD, 3'b010, 1'b1, 5'd7, 32'h102, 32'h0);
    step();
    check("mis_lw", misalign, 1);
    check("mis_lw_req", dmem_req, 0);
    check("mis_lw_rfwe", rf_we, 0);
    check("mis_lw_rdy", in_ready, 1);
    issue(OP_STORE, 3'b001, 1'b0, 5'd0, 32'h101, 32'h55);
    step();
    check("mis_sh", misalign, 1);
    check("mis_sh_req", dmem_req, 0);
    issue(OP_LOAD, 3'b011, 1'b1, 5'd7, 32'h100, 32'h0);
    step();
    check("ill_ld", misalign, 1);
    check("ill_ld_req", dmem_req, 0);
    check("ill_ld_rfwe", rf_we, 0);
    in_valid = 1'b0;
    step();
    check("mis_pulse_end", misalign, 0);
    check("mis_no_req", dmem_req, 0);

    // Zero-wait load to x0
    issue(OP_LOAD, 3'b010, 1'b1, 5'd0, 32'h200, 32'h0);
    step();
    in_valid = 1'b0;
    check("zw_req", dmem_req, 1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ack   = 1'b0;
    check("zw_req_drop", dmem_req, 0);
    check("zw_rfwe_x0", rf_we, 0);
    check("zw_rdy_wb", in_ready, 0);
    step();
    check("zw_rdy", in_ready, 1);
    check("zw_rfwe_end", rf_we, 0);

    // Reset while a load waits for its ack
    issue(OP_LOAD, 3'b010, 1'b1, 5'd7, 32'h300, 32'h0);
    step();
    in_valid = 1'b0;
    check("rm_req", dmem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_req_drop", dmem_req, 0);
    check("rm_rdy", in_ready, 1);
    check("rm_rfwe", rf_we, 0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rm_no_wb", rf_we, 0);
      check("rm_no_req", dmem_req, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
